// File: rtl/rasterizer_scan_controller.sv
// -----------------------------------------------------------------------------
// rasterizer_scan_controller
//
// Purpose:
//   Sequencer that sits in front of the triangle intersection detector. It
//   takes one triangle at a time over a valid/ready handshake and latches the
//   vertices for the detector. It pulses the detector load and computes the
//   screen-clamped bounding box. It then sweeps every box point through the
//   detector in row-major order, one point per cycle. Each returned
//   inside/outside decision is re-aligned with its coordinates to form a
//   per-pixel result stream.
//
// Ports:
//   i_clk, i_arst                    clock, asynchronous active-high reset
//   i_tri_valid / o_tri_ready        triangle handshake (ready only in IDLE)
//   i_tri_p{0,1,2}_{x,y}             offered vertices
//   o_load_triangle                  one-cycle load pulse to the detector
//   o_triangle_point_{0,1,2}_{x,y}   latched vertices, stable between accepts
//   i_triangle_loaded                detector "triangle loaded" flag
//   o_current_point_{x,y}            scan point, zero-extended to 2*W
//   i_point_inside_triangle          detector decision, DETECT_LATENCY late
//   o_pixel_valid/_x/_y/_inside      per-pixel result stream (no backpressure)
//   o_busy                           high whenever not IDLE
//   o_done                           one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module rasterizer_scan_controller #(
    parameter  int VERT_RESOLUTION  = 60,
    parameter  int HORIZ_RESOLUTION = 80,
    parameter  int DETECT_LATENCY   = 4,
    localparam int YW               = $clog2(VERT_RESOLUTION),
    localparam int XW               = $clog2(HORIZ_RESOLUTION)
) (
    input  logic            i_clk,
    input  logic            i_arst,
    input  logic            i_tri_valid,
    output logic            o_tri_ready,
    input  logic [XW-1:0]   i_tri_p0_x,
    input  logic [YW-1:0]   i_tri_p0_y,
    input  logic [XW-1:0]   i_tri_p1_x,
    input  logic [YW-1:0]   i_tri_p1_y,
    input  logic [XW-1:0]   i_tri_p2_x,
    input  logic [YW-1:0]   i_tri_p2_y,
    output logic            o_load_triangle,
    output logic [XW-1:0]   o_triangle_point_0_x,
    output logic [YW-1:0]   o_triangle_point_0_y,
    output logic [XW-1:0]   o_triangle_point_1_x,
    output logic [YW-1:0]   o_triangle_point_1_y,
    output logic [XW-1:0]   o_triangle_point_2_x,
    output logic [YW-1:0]   o_triangle_point_2_y,
    input  logic            i_triangle_loaded,
    output logic [2*XW-1:0] o_current_point_x,
    output logic [2*YW-1:0] o_current_point_y,
    input  logic            i_point_inside_triangle,
    output logic            o_pixel_valid,
    output logic [XW-1:0]   o_pixel_x,
    output logic [YW-1:0]   o_pixel_y,
    output logic            o_pixel_inside,
    output logic            o_busy,
    output logic            o_done
);

    localparam logic [XW-1:0] X_LAST = XW'(HORIZ_RESOLUTION - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VERT_RESOLUTION - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SCAN,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    // High from the second WAIT cycle on: the cycle before was also WAIT.
    logic wait_armed_q, wait_armed_d;

    logic [XW-1:0] v0x_q, v0x_d, v1x_q, v1x_d, v2x_q, v2x_d;
    logic [YW-1:0] v0y_q, v0y_d, v1y_q, v1y_d, v2y_q, v2y_d;

    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Coordinate tags travelling alongside the detector's internal pipeline.
    logic [DETECT_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [XW-1:0]             tag_x_q [DETECT_LATENCY];
    logic [XW-1:0]             tag_x_d [DETECT_LATENCY];
    logic [YW-1:0]             tag_y_q [DETECT_LATENCY];
    logic [YW-1:0]             tag_y_d [DETECT_LATENCY];

    logic          pix_valid_q, pix_valid_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic          pix_in_q, pix_in_d;

    logic          pipe_empty;
    logic [XW-1:0] bx_min, bx_max;
    logic [YW-1:0] by_min, by_max;

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        return (v > X_LAST) ? X_LAST : v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        return (v > Y_LAST) ? Y_LAST : v;
    endfunction

    // Bounding box of the offered triangle, before clamping.
    always_comb begin
        bx_min = i_tri_p0_x;
        bx_max = i_tri_p0_x;
        if (i_tri_p1_x < bx_min) bx_min = i_tri_p1_x;
        if (i_tri_p2_x < bx_min) bx_min = i_tri_p2_x;
        if (i_tri_p1_x > bx_max) bx_max = i_tri_p1_x;
        if (i_tri_p2_x > bx_max) bx_max = i_tri_p2_x;
        by_min = i_tri_p0_y;
        by_max = i_tri_p0_y;
        if (i_tri_p1_y < by_min) by_min = i_tri_p1_y;
        if (i_tri_p2_y < by_min) by_min = i_tri_p2_y;
        if (i_tri_p1_y > by_max) by_max = i_tri_p1_y;
        if (i_tri_p2_y > by_max) by_max = i_tri_p2_y;
    end

    // The last valid tag has become a pixel once both the tags and the
    // output register are empty.
    assign pipe_empty = (tag_vld_q == '0) && !pix_valid_q;

    always_comb begin
        state_d      = state_q;
        wait_armed_d = (state_q == S_WAIT);
        v0x_d  = v0x_q;
        v0y_d  = v0y_q;
        v1x_d  = v1x_q;
        v1y_d  = v1y_q;
        v2x_d  = v2x_q;
        v2y_d  = v2y_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        x_d    = x_q;
        y_d    = y_q;

        // Tag shift: a fresh tag enters at stage 0, invalid unless scanning.
        tag_vld_d[0] = 1'b0;
        tag_x_d[0]   = x_q;
        tag_y_d[0]   = y_q;
        for (int i = 1; i < DETECT_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_x_d[i]   = tag_x_q[i-1];
            tag_y_d[i]   = tag_y_q[i-1];
        end

        // Output stage: tag tail meets the detector decision for the same point.
        pix_valid_d = tag_vld_q[DETECT_LATENCY-1];
        pix_x_d     = tag_x_q[DETECT_LATENCY-1];
        pix_y_d     = tag_y_q[DETECT_LATENCY-1];
        pix_in_d    = tag_vld_q[DETECT_LATENCY-1] & i_point_inside_triangle;

        case (state_q)
            S_IDLE: begin
                if (i_tri_valid) begin
                    v0x_d   = i_tri_p0_x;
                    v0y_d   = i_tri_p0_y;
                    v1x_d   = i_tri_p1_x;
                    v1y_d   = i_tri_p1_y;
                    v2x_d   = i_tri_p2_x;
                    v2y_d   = i_tri_p2_y;
                    xmin_d  = clamp_x(bx_min);
                    xmax_d  = clamp_x(bx_max);
                    ymin_d  = clamp_y(by_min);
                    ymax_d  = clamp_y(by_max);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle still shows the previous triangle's flag.
                if (wait_armed_q && i_triangle_loaded) begin
                    x_d     = xmin_q;
                    y_d     = ymin_q;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                tag_vld_d[0] = 1'b1;
                // Compare before incrementing so counters never pass the clamp.
                if (x_q == xmax_q) begin
                    if (y_q == ymax_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        x_d = xmin_q;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q      <= S_IDLE;
            wait_armed_q <= 1'b0;
            v0x_q        <= '0;
            v0y_q        <= '0;
            v1x_q        <= '0;
            v1y_q        <= '0;
            v2x_q        <= '0;
            v2y_q        <= '0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymin_q       <= '0;
            ymax_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i < DETECT_LATENCY; i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_in_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_armed_q <= wait_armed_d;
            v0x_q        <= v0x_d;
            v0y_q        <= v0y_d;
            v1x_q        <= v1x_d;
            v1y_q        <= v1y_d;
            v2x_q        <= v2x_d;
            v2y_q        <= v2y_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymin_q       <= ymin_d;
            ymax_q       <= ymax_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tag_vld_q    <= tag_vld_d;
            for (int i = 0; i < DETECT_LATENCY; i++) begin
                tag_x_q[i] <= tag_x_d[i];
                tag_y_q[i] <= tag_y_d[i];
            end
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_in_q     <= pix_in_d;
        end
    end

    assign o_tri_ready          = (state_q == S_IDLE);
    assign o_busy               = (state_q != S_IDLE);
    assign o_load_triangle      = (state_q == S_LOAD);
    assign o_done               = (state_q == S_DRAIN) && pipe_empty;
    assign o_triangle_point_0_x = v0x_q;
    assign o_triangle_point_0_y = v0y_q;
    assign o_triangle_point_1_x = v1x_q;
    assign o_triangle_point_1_y = v1y_q;
    assign o_triangle_point_2_x = v2x_q;
    assign o_triangle_point_2_y = v2y_q;
    assign o_current_point_x    = {{XW{1'b0}}, x_q};
    assign o_current_point_y    = {{YW{1'b0}}, y_q};
    assign o_pixel_valid        = pix_valid_q;
    assign o_pixel_x            = pix_x_q;
    assign o_pixel_y            = pix_y_q;
    assign o_pixel_inside       = pix_in_q;

endmodule

// File: tb/tb_rasterizer_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_rasterizer_scan_controller
//
// Self-checking bench. A small detector stub answers load pulses and scan
// points. Expected pixel streams come from the bounding-box arithmetic and
// the timing formulas of the controller.
// -----------------------------------------------------------------------------
module tb_rasterizer_scan_controller;

    localparam int XW = 7;
    localparam int YW = 6;
    localparam int HR = 80;
    localparam int VR = 60;
    localparam int DL = 4;

    logic            i_clk = 1'b0;
    logic            i_arst;
    logic            i_tri_valid;
    logic            o_tri_ready;
    logic [XW-1:0]   i_tri_p0_x, i_tri_p1_x, i_tri_p2_x;
    logic [YW-1:0]   i_tri_p0_y, i_tri_p1_y, i_tri_p2_y;
    logic            o_load_triangle;
    logic [XW-1:0]   o_triangle_point_0_x, o_triangle_point_1_x, o_triangle_point_2_x;
    logic [YW-1:0]   o_triangle_point_0_y, o_triangle_point_1_y, o_triangle_point_2_y;
    logic            i_triangle_loaded;
    logic [2*XW-1:0] o_current_point_x;
    logic [2*YW-1:0] o_current_point_y;
    logic            i_point_inside_triangle;
    logic            o_pixel_valid;
    logic [XW-1:0]   o_pixel_x;
    logic [YW-1:0]   o_pixel_y;
    logic            o_pixel_inside;
    logic            o_busy;
    logic            o_done;

    rasterizer_scan_controller #(
        .VERT_RESOLUTION (VR),
        .HORIZ_RESOLUTION(HR),
        .DETECT_LATENCY  (DL)
    ) dut (
        .i_clk                  (i_clk),
        .i_arst                 (i_arst),
        .i_tri_valid            (i_tri_valid),
        .o_tri_ready            (o_tri_ready),
        .i_tri_p0_x             (i_tri_p0_x),
        .i_tri_p0_y             (i_tri_p0_y),
        .i_tri_p1_x             (i_tri_p1_x),
        .i_tri_p1_y             (i_tri_p1_y),
        .i_tri_p2_x             (i_tri_p2_x),
        .i_tri_p2_y             (i_tri_p2_y),
        .o_load_triangle        (o_load_triangle),
        .o_triangle_point_0_x   (o_triangle_point_0_x),
        .o_triangle_point_0_y   (o_triangle_point_0_y),
        .o_triangle_point_1_x   (o_triangle_point_1_x),
        .o_triangle_point_1_y   (o_triangle_point_1_y),
        .o_triangle_point_2_x   (o_triangle_point_2_x),
        .o_triangle_point_2_y   (o_triangle_point_2_y),
        .i_triangle_loaded      (i_triangle_loaded),
        .o_current_point_x      (o_current_point_x),
        .o_current_point_y      (o_current_point_y),
        .i_point_inside_triangle(i_point_inside_triangle),
        .o_pixel_valid          (o_pixel_valid),
        .o_pixel_x              (o_pixel_x),
        .o_pixel_y              (o_pixel_y),
        .o_pixel_inside         (o_pixel_inside),
        .o_busy                 (o_busy),
        .o_done                 (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Inclusive point-in-triangle via edge functions; degenerate triangles
    // count every coincident point as inside.
    function automatic bit inside_fn(input int px, input int py,
                                     input int ax, input int ay,
                                     input int bx, input int by,
                                     input int cx, input int cy);
        int e0, e1, e2;
        e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
        e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
        e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // ---------------- detector stub ----------------
    bit stale_mode = 1'b0;
    int since      = 0;
    bit prev_done  = 1'b0;
    int det_x [3]  = '{0, 0, 0};
    int det_y [3]  = '{0, 0, 0};
    int hx [DL];
    int hy [DL];
    bit loaded_real;

    initial begin
        for (int i = 0; i < DL; i++) begin
            hx[i] = 0;
            hy[i] = 0;
        end
    end

    always @(posedge i_clk) begin
        if (o_load_triangle) begin
            since     <= 1;
            prev_done <= (since >= 3);
            det_x[0]  <= int'(o_triangle_point_0_x);
            det_y[0]  <= int'(o_triangle_point_0_y);
            det_x[1]  <= int'(o_triangle_point_1_x);
            det_y[1]  <= int'(o_triangle_point_1_y);
            det_x[2]  <= int'(o_triangle_point_2_x);
            det_y[2]  <= int'(o_triangle_point_2_y);
        end else if (since != 0 && since < 10) begin
            since <= since + 1;
        end
        hx[0] <= int'(o_current_point_x);
        hy[0] <= int'(o_current_point_y);
        for (int i = 1; i < DL; i++) begin
            hx[i] <= hx[i-1];
            hy[i] <= hy[i-1];
        end
    end

    // Real detector: old flag one cycle after load, low next, high from load+3.
    assign loaded_real = (since == 1) ? prev_done : (since >= 3);
    assign i_triangle_loaded = stale_mode ? 1'b1 : loaded_real;
    assign i_point_inside_triangle = inside_fn(hx[DL-1], hy[DL-1], det_x[0], det_y[0],
                                               det_x[1], det_y[1], det_x[2], det_y[2]);

    // ---------------- stimulus / model ----------------
    int tx [3];
    int ty [3];
    int nx [3];
    int ny [3];
    int last_wait;

    task automatic drive_tri(input int ax[3], input int ay[3]);
        i_tri_p0_x = XW'(ax[0]);
        i_tri_p0_y = YW'(ay[0]);
        i_tri_p1_x = XW'(ax[1]);
        i_tri_p1_y = YW'(ay[1]);
        i_tri_p2_x = XW'(ax[2]);
        i_tri_p2_y = YW'(ay[2]);
    endtask

    function automatic logic [63:0] vtx_exp();
        return {25'd0, XW'(tx[0]), YW'(ty[0]), XW'(tx[1]), YW'(ty[1]), XW'(tx[2]), YW'(ty[2])};
    endfunction

    function automatic logic [63:0] vtx_act();
        return {25'd0, o_triangle_point_0_x, o_triangle_point_0_y, o_triangle_point_1_x,
                o_triangle_point_1_y, o_triangle_point_2_x, o_triangle_point_2_y};
    endfunction

    // Waits (bounded) for acceptance of tx/ty; returns the accept-cycle
    // negedge in progress, or 0 on timeout.
    task automatic offer(output bit ok);
        ok = 1'b0;
        i_tri_valid = 1'b1;
        drive_tri(tx, ty);
        last_wait = 0;
        for (int t = 0; t < 100; t++) begin
            if (o_tri_ready) begin
                ok = 1'b1;
                break;
            end
            last_wait++;
            @(negedge i_clk);
        end
        chk("accept", ok, 1);
    endtask

    // Offers tx/ty and checks every cycle from accept through o_done and the
    // following ready cycle. Called and returns at a negedge.
    task automatic run_tri(input bit stale, input bit queue_next);
        int xmn, xmx, ymn, ymx, w, n, fo, k, px, py;
        bit ok;
        xmn = tx[0]; xmx = tx[0]; ymn = ty[0]; ymx = ty[0];
        for (int i = 1; i < 3; i++) begin
            if (tx[i] < xmn) xmn = tx[i];
            if (tx[i] > xmx) xmx = tx[i];
            if (ty[i] < ymn) ymn = ty[i];
            if (ty[i] > ymx) ymx = ty[i];
        end
        if (xmn > HR - 1) xmn = HR - 1;
        if (xmx > HR - 1) xmx = HR - 1;
        if (ymn > VR - 1) ymn = VR - 1;
        if (ymx > VR - 1) ymx = VR - 1;
        w  = xmx - xmn + 1;
        n  = w * (ymx - ymn + 1);
        fo = stale ? 9 : 10;
        stale_mode = stale;
        offer(ok);
        if (!ok) begin
            i_tri_valid = 1'b0;
            return;
        end
        for (int c = 1; c <= fo + n; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                if (queue_next) drive_tri(nx, ny);
                else i_tri_valid = 1'b0;
            end
            k = c - fo;
            chk("busy", o_busy, 1);
            chk("ready_low", o_tri_ready, 0);
            chk("load", o_load_triangle, (c == 1));
            chk("done", o_done, (c == fo + n));
            chk("vertices", vtx_act(), vtx_exp());
            if (c == fo - 5) begin
                chk("first_pt_x", o_current_point_x, xmn);
                chk("first_pt_y", o_current_point_y, ymn);
            end
            chk("pix_valid", o_pixel_valid, (k >= 0 && k < n));
            if (k >= 0 && k < n) begin
                px = xmn + k % w;
                py = ymn + k / w;
                chk("pix_x", o_pixel_x, px);
                chk("pix_y", o_pixel_y, py);
                chk("pix_inside", o_pixel_inside,
                    inside_fn(px, py, tx[0], ty[0], tx[1], ty[1], tx[2], ty[2]));
            end else begin
                chk("pix_inside_idle", o_pixel_inside, 0);
            end
        end
        @(negedge i_clk);
        chk("ready_after_done", o_tri_ready, 1);
        chk("busy_after_done", o_busy, 0);
    endtask

    task automatic set_t(input int a0, b0, a1, b1, a2, b2);
        tx[0] = a0; ty[0] = b0; tx[1] = a1; ty[1] = b1; tx[2] = a2; ty[2] = b2;
    endtask

    initial begin
        bit ok;
        int bx, by;
        i_arst      = 1'b1;
        i_tri_valid = 1'b0;
        set_t(0, 0, 0, 0, 0, 0);
        drive_tri(tx, ty);

        // Reset state.
        @(negedge i_clk);
        chk("rst_ready", o_tri_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_load", o_load_triangle, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pix_valid", o_pixel_valid, 0);
        chk("rst_pix_inside", o_pixel_inside, 0);
        chk("rst_vertices", vtx_act(), 0);
        i_arst = 1'b0;
        @(negedge i_clk);

        // Basic triangle: 16 pixels, inside where x+y <= 3.
        set_t(0, 0, 3, 0, 0, 3);
        run_tri(0, 0);

        // Single point.
        set_t(5, 5, 5, 5, 5, 5);
        run_tri(0, 0);

        // Clamping in x: box 70..79 by 0..1.
        set_t(70, 0, 90, 0, 70, 1);
        run_tri(0, 0);

        // Clamping in y as well.
        set_t(10, 58, 12, 63, 11, 61);
        run_tri(0, 0);

        // Stale loaded flag held high by the stub.
        set_t(2, 2, 6, 2, 2, 5);
        run_tri(1, 0);

        // Back-to-back: second triangle queued while the first scans.
        set_t(20, 10, 23, 12, 21, 14);
        nx[0] = 40; ny[0] = 30; nx[1] = 42; ny[1] = 30; nx[2] = 40; ny[2] = 33;
        run_tri(0, 1);
        tx = nx;
        ty = ny;
        run_tri(0, 0);
        chk("b2b_accept_wait", last_wait, 0);

        // Asynchronous reset in the middle of a scan.
        set_t(10, 10, 14, 10, 10, 13);
        stale_mode = 1'b0;
        offer(ok);
        for (int c = 1; c <= 8; c++) begin
            @(negedge i_clk);
            if (c == 1) i_tri_valid = 1'b0;
        end
        chk("mid_scan_busy", o_busy, 1);
        i_arst = 1'b1;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_ready", o_tri_ready, 1);
        chk("arst_pix_valid", o_pixel_valid, 0);
        chk("arst_load", o_load_triangle, 0);
        chk("arst_done", o_done, 0);
        chk("arst_cur_x", o_current_point_x, 0);
        @(negedge i_clk);
        i_arst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            chk("post_rst_pix_valid", o_pixel_valid, 0);
            chk("post_rst_busy", o_busy, 0);
        end
        set_t(30, 20, 33, 22, 31, 24);
        run_tri(0, 0);

        // Randomized triangles, some near or beyond the screen edges.
        for (int r = 0; r < 12; r++) begin
            bx = $urandom_range(0, 119);
            by = $urandom_range(0, 57);
            for (int i = 0; i < 3; i++) begin
                tx[i] = bx + $urandom_range(0, 8);
                ty[i] = by + $urandom_range(0, 6);
            end
            run_tri($urandom_range(0, 1), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
